data_stack: RTL

DATA_STACK -- requirements
Module: data_stack

---
 rtl/data_stack_if.sv | 30 +++
 rtl/data_stack.sv | 137 +++++++++++++
 2 files changed

// File: rtl/data_stack_if.sv
// data_stack_if -- handshake/data bundle between a stack controller and data_stack.
//   master : controller side; drives rst_stack, push, pop, data_in and observes status
//   slave  : stack side; receives commands and drives data_out, pop_valid, count,
//            empty, full, overflow, underflow
interface data_stack_if #(
   parameter int WIDTH = 16,
   parameter int PTR_W = 5
);
   logic             rst_stack;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             pop_valid;
   logic [PTR_W:0]   count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output rst_stack, push, pop, data_in,
      input  data_out, pop_valid, count, empty, full, overflow, underflow
   );

   modport slave (
      input  rst_stack, push, pop, data_in,
      output data_out, pop_valid, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/data_stack.sv
// data_stack -- LIFO of DEPTH x WIDTH registers with registered pop data.
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : data_stack_if.slave (rst_stack, push, pop, data_in -> data_out,
//          pop_valid, count, empty, full, overflow, underflow)
// Build option: define DATA_STACK_GUARD_EN to ignore push-while-full and
// pop-while-empty and raise sticky overflow/underflow flags instead. Without it
// the pointer wraps and both flags stay 0.
module data_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int PTR_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   data_stack_if.slave  bus
);
   localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             pop_valid_q, pop_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [PTR_W:0]   count_m1;
   logic [PTR_W-1:0] top_addr;
   logic             empty, full;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_DEPTH);
   assign count_m1 = count_q - CNT_ONE;
   // When empty this wraps to DEPTH-1, which is exactly the unguarded underflow read.
   assign top_addr = count_m1[PTR_W-1:0];

   always_comb begin
      count_d     = count_q;
      data_out_d  = data_out_q;
      pop_valid_d = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      wr_en       = 1'b0;
      wr_addr     = count_q[PTR_W-1:0];

      if (bus.rst_stack) begin
         count_d     = '0;
         data_out_d  = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         unique case ({bus.push, bus.pop})
            2'b10: begin
               if (!full) begin
                  wr_en   = 1'b1;
                  count_d = count_q + CNT_ONE;
               end else begin
`ifdef DATA_STACK_GUARD_EN
                  overflow_d = 1'b1;
`else
                  // Low pointer bits are already 0 at count==DEPTH: wraps to mem[0].
                  wr_en   = 1'b1;
                  count_d = CNT_ONE;
`endif
               end
            end
            2'b01: begin
               if (!empty) begin
                  data_out_d  = mem_q[top_addr];
                  count_d     = count_m1;
                  pop_valid_d = 1'b1;
               end else begin
`ifdef DATA_STACK_GUARD_EN
                  underflow_d = 1'b1;
`else
                  data_out_d  = mem_q[top_addr];
                  count_d     = CNT_DEPTH - CNT_ONE;
                  pop_valid_d = 1'b1;
`endif
               end
            end
            2'b11: begin
               if (!empty) begin
                  // Swap the top entry: old top goes out, new value replaces it.
                  // A push that succeeds this way is not an overflow even when full.
                  data_out_d  = mem_q[top_addr];
                  wr_en       = 1'b1;
                  wr_addr     = top_addr;
                  pop_valid_d = 1'b1;
               end else begin
                  // Pop fails, push lands in slot 0.
                  wr_en   = 1'b1;
                  count_d = CNT_ONE;
`ifdef DATA_STACK_GUARD_EN
                  underflow_d = 1'b1;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         data_out_q  <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; rst still blocks a write that coincides with an edge.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_addr] <= bus.data_in;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.pop_valid = pop_valid_q;
   assign bus.count     = count_q;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule
